ball_motion_engine: RTL and testbench

//  Parametrised ball location processor for Pong: multi-pixel x speed, real paddle-hit detection,

---
 rtl/pong_pkg.sv | 19 +
 rtl/frame_tick_counter.sv | 32 +++
 rtl/ball_motion_engine.sv | 194 +++++++++++++++++++
 tb/tb_ball_motion_engine.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: motion-engine state encoding, direction constants and screen defaults.
package pong_pkg;

  typedef enum logic [1:0] {
    S_WAIT_TRANSACTION,
    S_IDLE,
    S_UPDATE,
    S_WAIT_FRAME
  } state_t;

  localparam logic INCREASE = 1'b1;
  localparam logic DECREASE = 1'b0;

  localparam int unsigned DEF_COORD_W       = 9;
  localparam int unsigned DEF_BALL_SIZE     = 4;
  localparam int unsigned DEF_PADDLE_HEIGHT = 48;
  localparam int unsigned DEF_SCREEN_HEIGHT = 240;

endpackage

// File: rtl/frame_tick_counter.sv
// Saturating frame-tick counter: counts clocks up to FRAME_RATE_COUNT and holds there until cleared.
module frame_tick_counter #(
  parameter logic [31:0] FRAME_RATE_COUNT = 32'd3333332
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic done
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != FRAME_RATE_COUNT) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == FRAME_RATE_COUNT);

endmodule

// File: rtl/ball_motion_engine.sv
// Pong ball location processor: paddle hit/miss detection, serve cycle, one position transaction per frame.
// Optional feature: define BALL_SPEEDUP_EN to raise |vx| by one on each paddle hit (capped at MAX_SPEED).
module ball_motion_engine
  import pong_pkg::*;
#(
  parameter int unsigned COORD_W          = DEF_COORD_W,
  parameter int unsigned BALL_SIZE        = DEF_BALL_SIZE,
  parameter int unsigned PADDLE_HEIGHT    = DEF_PADDLE_HEIGHT,
  parameter int unsigned SCREEN_HEIGHT    = DEF_SCREEN_HEIGHT,
  parameter int unsigned LEFT_COLLISION   = 10,
  parameter int unsigned RIGHT_COLLISION  = 310,
  parameter int unsigned SERVE_X          = 160,
  parameter int unsigned SERVE_Y          = 120,
  parameter logic [31:0] FRAME_RATE_COUNT = 32'd3333332,
  parameter int unsigned INIT_SPEED       = 1,
  parameter int unsigned MAX_SPEED        = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [2:0]         in_color,
  input  logic [COORD_W-1:0] paddle_left_y,
  input  logic [COORD_W-1:0] paddle_right_y,
  input  logic               serve,
  input  logic               m_ready,
  output logic               m_valid,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y,
  output logic [2:0]         out_color,
  output logic               hit,
  output logic               score_left,
  output logic               score_right
);

  localparam int unsigned W = COORD_W + 1;
  localparam logic [W-1:0] BALL_E    = W'(BALL_SIZE);
  localparam logic [W-1:0] PADDLE_E  = W'(PADDLE_HEIGHT);
  localparam logic [W-1:0] LEFT_E    = W'(LEFT_COLLISION);
  localparam logic [W-1:0] RIGHT_E   = W'(RIGHT_COLLISION);
  localparam logic [COORD_W-1:0] BOTTOM_Y   = COORD_W'(SCREEN_HEIGHT - BALL_SIZE);
  localparam logic [COORD_W-1:0] RIGHT_FACE = COORD_W'(RIGHT_COLLISION - BALL_SIZE);
  localparam logic [COORD_W-1:0] LEFT_FACE  = COORD_W'(LEFT_COLLISION);
  localparam logic [COORD_W-1:0] SERVE_XC   = COORD_W'(SERVE_X);
  localparam logic [COORD_W-1:0] SERVE_YC   = COORD_W'(SERVE_Y);
  localparam logic [COORD_W-1:0] INIT_SPD   = COORD_W'(INIT_SPEED);
  localparam logic [COORD_W-1:0] SPEED_CAP  =
    COORD_W'((MAX_SPEED < INIT_SPEED) ? INIT_SPEED : MAX_SPEED);
`ifdef BALL_SPEEDUP_EN
  localparam logic SPEEDUP = 1'b1;
`else
  localparam logic SPEEDUP = 1'b0;
`endif

  state_t state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, speed_q, speed_d;
  logic vx_q, vx_d, vy_q, vy_d, running_q, running_d;
  logic hit_q, hit_d, sl_q, sl_d, sr_q, sr_d;
  logic tick_clear, tick_done;

  logic [W-1:0] xe, ye, spd, nx, py;
  logic [COORD_W-1:0] ny;
  logic right_test, left_test, overlap, ny_vy;

  assign tick_clear = (state_q == S_WAIT_TRANSACTION);

  frame_tick_counter #(
    .FRAME_RATE_COUNT(FRAME_RATE_COUNT)
  ) u_frame_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tick_clear),
    .done   (tick_done)
  );

  // Candidate next position and collision tests, widened one bit so x never wraps.
  always_comb begin
    xe  = {1'b0, x_q};
    ye  = {1'b0, y_q};
    spd = {1'b0, speed_q};
    if (vx_q == INCREASE) begin
      nx = xe + spd;
    end else begin
      nx = (xe > spd) ? (xe - spd) : '0;
    end
    right_test = (vx_q == INCREASE) && ((nx + BALL_E) >= RIGHT_E);
    left_test  = (vx_q == DECREASE) && (nx <= LEFT_E);
    py         = right_test ? {1'b0, paddle_right_y} : {1'b0, paddle_left_y};
    overlap    = ((ye + BALL_E) > py) && (ye < (py + PADDLE_E));
    ny         = y_q;
    ny_vy      = vy_q;
    if (vy_q == INCREASE) begin
      if (y_q == BOTTOM_Y) begin
        ny_vy = DECREASE;
        ny    = y_q - COORD_W'(1);
      end else begin
        ny = y_q + COORD_W'(1);
      end
    end else begin
      if (y_q == '0) begin
        ny_vy = INCREASE;
        ny    = COORD_W'(1);
      end else begin
        ny = y_q - COORD_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    speed_d   = speed_q;
    running_d = running_q;
    hit_d     = 1'b0;
    sl_d      = 1'b0;
    sr_d      = 1'b0;
    case (state_q)
      S_WAIT_TRANSACTION: begin
        if (m_ready) state_d = running_q ? S_UPDATE : S_IDLE;
      end
      S_IDLE: begin
        if (serve) begin
          running_d = 1'b1;
          state_d   = S_WAIT_FRAME;
        end
      end
      S_UPDATE: begin
        state_d = tick_done ? S_WAIT_TRANSACTION : S_WAIT_FRAME;
        if ((right_test || left_test) && !overlap) begin
          // Miss: the y step of this frame is dropped along with the rest of the rally state.
          sl_d      = right_test;
          sr_d      = left_test;
          x_d       = SERVE_XC;
          y_d       = SERVE_YC;
          speed_d   = INIT_SPD;
          running_d = 1'b0;
          vx_d      = right_test ? INCREASE : DECREASE;
        end else begin
          y_d  = ny;
          vy_d = ny_vy;
          if (right_test || left_test) begin
            hit_d = 1'b1;
            x_d   = right_test ? RIGHT_FACE : LEFT_FACE;
            vx_d  = ~vx_q;
            if (SPEEDUP && (speed_q < SPEED_CAP)) speed_d = speed_q + COORD_W'(1);
          end else begin
            x_d = nx[COORD_W-1:0];
          end
        end
      end
      S_WAIT_FRAME: begin
        if (tick_done) state_d = S_WAIT_TRANSACTION;
      end
      default: state_d = S_WAIT_TRANSACTION;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_WAIT_TRANSACTION;
      x_q       <= SERVE_XC;
      y_q       <= SERVE_YC;
      vx_q      <= INCREASE;
      vy_q      <= INCREASE;
      speed_q   <= INIT_SPD;
      running_q <= 1'b0;
      hit_q     <= 1'b0;
      sl_q      <= 1'b0;
      sr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      speed_q   <= speed_d;
      running_q <= running_d;
      hit_q     <= hit_d;
      sl_q      <= sl_d;
      sr_q      <= sr_d;
    end
  end

  // Gated by reset_n so the pending transaction disappears as soon as reset asserts.
  assign m_valid     = reset_n && (state_q == S_WAIT_TRANSACTION);
  assign box_x       = x_q;
  assign box_y       = y_q;
  assign out_color   = in_color;
  assign hit         = hit_q;
  assign score_left  = sl_q;
  assign score_right = sr_q;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine with a short frame period; honours BALL_SPEEDUP_EN like the design.
module tb_ball_motion_engine;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] in_color = 3'b101;
  logic [8:0] paddle_left_y = 9'd400;
  logic [8:0] paddle_right_y = 9'd180;
  logic       serve = 1'b0;
  logic       m_ready = 1'b0;
  logic       m_valid;
  logic [8:0] box_x, box_y;
  logic [2:0] out_color;
  logic       hit, score_left, score_right;

  int checks = 0;
  int errors = 0;

`ifdef BALL_SPEEDUP_EN
  localparam int MAXSPD = 4;
`else
  localparam int MAXSPD = 1;
`endif

  int m_x, m_y, m_vx, m_vy, m_spd, m_pl, m_pr;
  bit ev_hit, ev_sl, ev_sr;

  ball_motion_engine #(
    .FRAME_RATE_COUNT(32'd4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_color      (in_color),
    .paddle_left_y (paddle_left_y),
    .paddle_right_y(paddle_right_y),
    .serve         (serve),
    .m_ready       (m_ready),
    .m_valid       (m_valid),
    .box_x         (box_x),
    .box_y         (box_y),
    .out_color     (out_color),
    .hit           (hit),
    .score_left    (score_left),
    .score_right   (score_right)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n = 1'b0;
    serve   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic model_reset();
    m_x = 160; m_y = 120; m_vx = 1; m_vy = 1; m_spd = 1;
  endtask

  task automatic set_fixed_paddles(input int l, input int r);
    paddle_left_y  = 9'(l);
    paddle_right_y = 9'(r);
    m_pl = l;
    m_pr = r;
  endtask

  task automatic track_paddles();
    int p;
    p = (m_y >= 20) ? m_y - 20 : 0;
    set_fixed_paddles(p, p);
  endtask

  // Reference ball behaviour for one frame update.
  task automatic model_step();
    int nx, ny, nvy, py;
    bit rt, lt;
    ev_hit = 0; ev_sl = 0; ev_sr = 0;
    nx = m_x + m_vx * m_spd;
    if (nx < 0) nx = 0;
    rt = (m_vx > 0) && (nx + 4 >= 310);
    lt = (m_vx < 0) && (nx <= 10);
    nvy = m_vy;
    if (m_vy > 0) begin
      if (m_y == 236) begin nvy = -1; ny = 235; end else ny = m_y + 1;
    end else begin
      if (m_y == 0) begin nvy = 1; ny = 1; end else ny = m_y - 1;
    end
    if (rt || lt) begin
      py = rt ? m_pr : m_pl;
      if ((m_y + 4 > py) && (m_y < py + 48)) begin
        ev_hit = 1;
        m_x  = rt ? 306 : 10;
        m_vx = -m_vx;
        if (m_spd < MAXSPD) m_spd++;
        m_y  = ny;
        m_vy = nvy;
      end else begin
        ev_sl = rt; ev_sr = lt;
        m_x = 160; m_y = 120; m_spd = 1;
        m_vx = rt ? 1 : -1;
      end
    end else begin
      m_x = nx; m_y = ny; m_vy = nvy;
    end
  endtask

  // Accept the current transaction (m_ready held high) and wait for the next one.
  task automatic next_txn(output bit ok, output int x, output int y,
                          output int nh, output int nl, output int nr);
    ok = 0; x = 0; y = 0; nh = 0; nl = 0; nr = 0;
    @(posedge clock);
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      nh += int'(hit);
      nl += int'(score_left);
      nr += int'(score_right);
      if (m_valid) begin
        x = int'(box_x);
        y = int'(box_y);
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_rally(input int max_txn, input int max_hits, input bit track,
                           output int bad, output int first_bad, output int hits,
                           output int sl, output int sr, output bit missed,
                           output int hit_x, output int last_x, output int last_y);
    bit ok;
    int x, y, nh, nl, nr, mh;
    bad = 0; first_bad = -1; hits = 0; sl = 0; sr = 0; missed = 0;
    hit_x = -1; last_x = -1; last_y = -1; mh = 0;
    for (int t = 0; t < max_txn; t++) begin
      if (track) track_paddles();
      model_step();
      next_txn(ok, x, y, nh, nl, nr);
      if (!ok) begin
        bad++;
        if (first_bad < 0) first_bad = t;
        break;
      end
      hits += nh; sl += nl; sr += nr;
      last_x = x; last_y = y;
      if (x != m_x || y != m_y || nh != int'(ev_hit) || nl != int'(ev_sl) || nr != int'(ev_sr)) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
      if (ev_hit) begin
        mh++;
        if (hit_x < 0) hit_x = x;
      end
      if (ev_sl || ev_sr) begin
        missed = 1;
        break;
      end
      if (mh >= max_hits) break;
    end
  endtask

  task automatic start_game(output bit ok, output int x, output int y);
    int nh, nl, nr;
    @(negedge clock);
    serve = 1'b1;
    @(posedge clock);
    @(negedge clock);
    serve = 1'b0;
    next_txn(ok, x, y, nh, nl, nr);
  endtask

  task automatic check_idle(input string name);
    int seen;
    seen = 0;
    @(posedge clock);
    repeat (20) begin
      @(negedge clock);
      seen += int'(m_valid);
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL %s: m_valid high for %0d cycles, required 0", name, seen);
    end
  endtask

  task automatic test_reset();
    m_ready = 1'b0;
    do_reset();
    @(negedge clock);
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL reset_valid: m_valid=%b required 1", m_valid); end
    checks++;
    if (box_x !== 9'd160 || box_y !== 9'd120) begin
      errors++; $display("FAIL reset_box: (%0d,%0d) required (160,120)", box_x, box_y);
    end
    checks++;
    if ({hit, score_left, score_right} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: %b required 000", {hit, score_left, score_right});
    end
    checks++;
    if (out_color !== 3'b101) begin errors++; $display("FAIL color_a: %b required 101", out_color); end
    in_color = 3'b010;
    #1;
    checks++;
    if (out_color !== 3'b010) begin errors++; $display("FAIL color_b: %b required 010", out_color); end
  endtask

  task automatic test_idle_after_reset();
    m_ready = 1'b1;
    check_idle("idle_after_reset");
    checks++;
    if (box_x !== 9'd160 || box_y !== 9'd120) begin
      errors++; $display("FAIL idle_box: (%0d,%0d) required (160,120)", box_x, box_y);
    end
  endtask

  task automatic test_serve_motion();
    bit ok, missed;
    int x, y, bad, fb, h, sl, sr, hx, lx, ly;
    model_reset();
    set_fixed_paddles(400, 180);
    start_game(ok, x, y);
    checks++;
    if (!ok || x != 160 || y != 120) begin
      errors++; $display("FAIL serve_first: ok=%0d (%0d,%0d) required ok=1 (160,120)", ok, x, y);
    end
    run_rally(10, 1000, 0, bad, fb, h, sl, sr, missed, hx, lx, ly);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL serve_steps: %0d bad transactions (first #%0d) required 0", bad, fb); end
    checks++;
    if (lx != 170 || ly != 130) begin errors++; $display("FAIL serve_pos10: (%0d,%0d) required (170,130)", lx, ly); end
  endtask

  task automatic test_bottom_bounce();
    bit missed;
    int bad, fb, h, sl, sr, hx, lx, ly;
    run_rally(107, 1000, 0, bad, fb, h, sl, sr, missed, hx, lx, ly);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bounce_steps: %0d bad transactions (first #%0d) required 0", bad, fb); end
    checks++;
    if (lx != 277 || ly != 235) begin errors++; $display("FAIL bottom_bounce: (%0d,%0d) required (277,235)", lx, ly); end
  endtask

  task automatic test_paddle_hit();
    bit missed;
    int bad, fb, h, sl, sr, hx, lx, ly;
    run_rally(2000, 1000, 0, bad, fb, h, sl, sr, missed, hx, lx, ly);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hit_rally: %0d bad transactions (first #%0d) required 0", bad, fb); end
    checks++;
    if (hx != 306) begin errors++; $display("FAIL hit_clamp: x=%0d required 306", hx); end
    checks++;
    if (h != 1 || sl != 0 || sr != 1 || !missed) begin
      errors++; $display("FAIL hit_pulses: hit=%0d sl=%0d sr=%0d missed=%0d required 1 0 1 1", h, sl, sr, missed);
    end
    checks++;
    if (lx != 160 || ly != 120) begin errors++; $display("FAIL left_miss_box: (%0d,%0d) required (160,120)", lx, ly); end
    check_idle("idle_after_left_miss");
  endtask

  task automatic test_speedup();
    bit ok, missed;
    int x, y, bad, fb, h, sl, sr, hx, lx, ly;
    m_ready = 1'b1;
    do_reset();
    model_reset();
    track_paddles();
    start_game(ok, x, y);
    checks++;
    if (!ok || x != 160 || y != 120) begin
      errors++; $display("FAIL speedup_first: ok=%0d (%0d,%0d) required ok=1 (160,120)", ok, x, y);
    end
    run_rally(3000, 6, 1, bad, fb, h, sl, sr, missed, hx, lx, ly);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL speedup_rally: %0d bad transactions (first #%0d) required 0", bad, fb); end
    checks++;
    if (h != 6 || missed) begin errors++; $display("FAIL speedup_hits: hits=%0d missed=%0d required 6 0", h, missed); end
  endtask

  task automatic test_right_miss();
    bit ok, missed;
    int x, y, bad, fb, h, sl, sr, hx, lx, ly;
    do_reset();
    model_reset();
    set_fixed_paddles(400, 0);
    start_game(ok, x, y);
    run_rally(500, 1000, 0, bad, fb, h, sl, sr, missed, hx, lx, ly);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL miss_rally: %0d bad transactions (first #%0d) required 0", bad, fb); end
    checks++;
    if (sl != 1 || sr != 0 || h != 0) begin
      errors++; $display("FAIL miss_pulses: sl=%0d sr=%0d hit=%0d required 1 0 0", sl, sr, h);
    end
    checks++;
    if (lx != 160 || ly != 120) begin errors++; $display("FAIL right_miss_box: (%0d,%0d) required (160,120)", lx, ly); end
    check_idle("idle_after_right_miss");
    start_game(ok, x, y);
    run_rally(1, 1000, 0, bad, fb, h, sl, sr, missed, hx, lx, ly);
    checks++;
    if (!ok || lx != 161 || ly != 119) begin
      errors++; $display("FAIL reserve_dir: ok=%0d (%0d,%0d) required ok=1 (161,119)", ok, lx, ly);
    end
  endtask

  task automatic test_reset_mid_wait();
    int waited;
    m_ready = 1'b0;
    waited = 0;
    while (!m_valid && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    repeat (5) @(negedge clock);
    checks++;
    if (m_valid !== 1'b1 || box_x !== 9'd161 || box_y !== 9'd119) begin
      errors++; $display("FAIL hold_no_ready: valid=%b (%0d,%0d) required 1 (161,119)", m_valid, box_x, box_y);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: m_valid=%b required 0", m_valid); end
    checks++;
    if (box_x !== 9'd160 || box_y !== 9'd120) begin
      errors++; $display("FAIL async_reset_box: (%0d,%0d) required (160,120)", box_x, box_y);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid: m_valid=%b required 1", m_valid); end
  endtask

  initial begin
    test_reset();
    test_idle_after_reset();
    test_serve_motion();
    test_bottom_bounce();
    test_paddle_hit();
    test_speedup();
    test_right_miss();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
